// File: rtl/gnroot_u.sv
// Stochastic ROOT-th root: a saturating up/down counter per channel driven by the
// input bitstream (up) and by ROOT consecutive output ones (down).
module gnroot_u #(
  parameter int unsigned BW   = 5,
  parameter int unsigned CH   = 4,
  parameter int unsigned ROOT = 2,
  parameter int unsigned INIT = 2 ** (BW - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic [CH-1:0]    clr,
  input  logic [CH*BW-1:0] rand_num,
  input  logic [CH-1:0]    in,
  output logic [CH-1:0]    out,
  output logic [CH-1:0]    sat
);

  localparam int unsigned    HW       = ROOT - 1;
  localparam logic [BW-1:0]  MAXV     = '1;
  localparam logic [BW-1:0]  INITV    = BW'(INIT);
  localparam logic           INIT_SAT = (INITV == '0) || (INITV == MAXV);

  logic [BW-1:0] r_cnt  [CH];
  logic [HW-1:0] r_hist [CH];
  logic [CH-1:0] r_sat;

  logic [BW-1:0] w_cnt_nx  [CH];
  logic [HW-1:0] w_hist_nx [CH];
  logic [HW:0]   w_shift   [CH];
  logic [CH-1:0] w_sat_nx;
  logic [CH-1:0] w_inc;
  logic [CH-1:0] w_dec;

  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      out[c] = r_cnt[c] > rand_num[c*BW +: BW];
    end
  end

  // A decrement needs the current output plus the previous ROOT-1 outputs all high,
  // which is what makes the steady-state output probability the ROOT-th root.
  always_comb begin
    for (int unsigned c = 0; c < CH; c++) begin
      w_inc[c]     = in[c];
      w_dec[c]     = out[c] & (&r_hist[c]);
      w_shift[c]   = {r_hist[c], out[c]};
      w_cnt_nx[c]  = r_cnt[c];
      w_hist_nx[c] = r_hist[c];
      if (clr[c]) begin
        w_cnt_nx[c]  = INITV;
        w_hist_nx[c] = '0;
      end else if (en[c]) begin
        w_hist_nx[c] = w_shift[c][HW-1:0];
        if (w_inc[c] && !w_dec[c] && (r_cnt[c] != MAXV)) begin
          w_cnt_nx[c] = r_cnt[c] + 1'b1;
        end else if (!w_inc[c] && w_dec[c] && (r_cnt[c] != '0)) begin
          w_cnt_nx[c] = r_cnt[c] - 1'b1;
        end
      end
      w_sat_nx[c] = (w_cnt_nx[c] == '0) || (w_cnt_nx[c] == MAXV);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < CH; c++) begin
        r_cnt[c]  <= INITV;
        r_hist[c] <= '0;
      end
      r_sat <= {CH{INIT_SAT}};
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        r_cnt[c]  <= w_cnt_nx[c];
        r_hist[c] <= w_hist_nx[c];
      end
      r_sat <= w_sat_nx;
    end
  end

  assign sat = r_sat;

endmodule

// File: doc/gnroot_u.md
GNROOT_U -- requirements
Module: gnroot_u

Interface
REQ-001 SHALL provide parameter BW, default 5, width of the per-channel counter and random number.
REQ-002 SHALL provide parameter CH, default 4, number of independent channels.
REQ-003 SHALL provide parameter ROOT, default 2, legal range 2..4; the block computes the ROOT-th root of the input bitstream probability.
REQ-004 SHALL provide parameter INIT, default 2^(BW-1), counter value after reset or clear.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  CH  per-channel update enable.
REQ-009 clr  input  CH  per-channel synchronous clear.
REQ-010 rand_num  input  CH*BW  per-channel random number, channel c at bits [c*BW +: BW].
REQ-011 in  input  CH  per-channel unipolar input bitstream.
REQ-012 out  output  CH  per-channel unipolar root bitstream.
REQ-013 sat  output  CH  per-channel registered flag, counter at 0 or 2^BW-1.

Function
REQ-014 Each channel SHALL hold a BW-bit unsigned counter cnt[c] and a (ROOT-1)-bit history shift register hist[c] of past out[c] values.
REQ-015 out[c] SHALL be combinational: out[c] = (cnt[c] > rand_num[c]), unsigned compare, zero latency from rand_num.
REQ-016 inc[c] SHALL equal in[c]; dec[c] SHALL equal out[c] AND all ROOT-1 bits of hist[c].
REQ-017 When en[c]=1, hist[c] SHALL shift in out[c] (oldest bit discarded) each cycle.
REQ-018 When en[c]=1, inc=1 and dec=0, cnt[c] SHALL increment by 1 unless cnt[c]=2^BW-1, where it holds (no wrap).
REQ-019 When en[c]=1, inc=0 and dec=1, cnt[c] SHALL decrement by 1 unless cnt[c]=0, where it holds (no wrap).
REQ-020 When inc and dec are both 1 or both 0, cnt[c] SHALL hold.
REQ-021 When en[c]=0, cnt[c] and hist[c] SHALL hold; out[c] still follows REQ-015.
REQ-022 clr[c]=1 SHALL set cnt[c]=INIT and hist[c]=0 on the next edge, overriding en[c] and all inc/dec activity.
REQ-023 sat[c] SHALL be registered, updated every cycle to (next cnt[c]==0 or next cnt[c]==2^BW-1).
REQ-024 Channels SHALL be fully independent; no state or signal of channel c affects channel d.
REQ-025 In steady state, the mean of out[c] SHALL satisfy mean(out)^ROOT = mean(in), within stochastic error.

Reset
REQ-026 rst=1 SHALL, on the next edge, set every cnt[c]=INIT, hist[c]=0, sat[c]=(INIT==0 or INIT==2^BW-1); priority over clr and en.
REQ-027 After reset, out[c] SHALL equal (INIT > rand_num[c]); rst asserted mid-operation SHALL discard all accumulated state in one cycle.

Verification
REQ-028 Reset (BW=5, defaults): rst=1 one cycle -> cnt=16 all channels, sat=0; rand_num=15 -> out=1, rand_num=16 -> out=0.
REQ-029 Saturation high: in=1, rand_num=31, en=1 -> cnt reaches 31 after 15 cycles, holds at 31, sat=1, out=0, no wrap.
REQ-030 Saturation low (ROOT=2): in=0, rand_num=0, en=1 -> first cycle holds (hist=0), then cnt decrements 1/cycle to 0, holds at 0, sat=1, no wrap to 31.
REQ-031 Enable/clear: en=0 with in=1 for 10 cycles -> cnt stays 16; clr=1 with en=0 after cnt=25 -> cnt=16, hist=0 next cycle.
REQ-032 Convergence: in Bernoulli p=0.25, rand_num uniform LFSR, ROOT=2 -> mean(out) over 4096 cycles after 256-cycle warmup in 0.50+/-0.05; ROOT=3, p=0.125 -> 0.50+/-0.05.
REQ-033 Independence: drive only channel 2 with in=1, others in=0 and rand_num=31 -> channels 0,1,3 cnt stay 16 while channel 2 climbs.
